// File: rtl/socket_ctrl_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : socket_ctrl_regs_if
// Brief    : Control-port bundle between the clock-crossing bridge (master)
//            and the socket-side register file (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface socket_ctrl_regs_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] cl_ctrl_addr_ff;
  logic              cl_ctrl_ce_ff;
  logic              cl_ctrl_we_ff;
  logic [DATA_W-1:0] cl_ctrl_d_ff;
  logic [DATA_W-1:0] cl_ctrl_q_ff;
  logic              cl_done_ff;

  // Bridge side: drives the access, receives read data and done level.
  modport master (
    output cl_ctrl_addr_ff, cl_ctrl_ce_ff, cl_ctrl_we_ff, cl_ctrl_d_ff,
    input  cl_ctrl_q_ff, cl_done_ff
  );

  // Register-file side.
  modport slave (
    input  cl_ctrl_addr_ff, cl_ctrl_ce_ff, cl_ctrl_we_ff, cl_ctrl_d_ff,
    output cl_ctrl_q_ff, cl_done_ff
  );
endinterface
`default_nettype wire

// File: rtl/socket_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module   : socket_ctrl_regs
// Brief    : Socket-side control registers and kernel launch sequencer.
//            Holds kernel arguments, issues a one-cycle start pulse, tracks
//            busy/done and counts busy cycles.
//            Optional macro SOCKET_CTRL_TIMEOUT_EN adds the TIMEOUT register
//            at 0x004 and the STATUS.timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
module socket_ctrl_regs #(
  parameter int NUM_ARGS = 8,
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int Q_LAT    = 1
) (
  input  wire logic                       clk,
  input  wire logic                       socket_reset,
  socket_ctrl_regs_if.slave               ctrl,
  output logic                            kernel_start,
  output logic                            kernel_busy,
  input  wire logic                       kernel_done,
  output logic [NUM_ARGS*DATA_W-1:0]      kernel_args
);

  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(16'h000);
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(16'h001);
  localparam logic [ADDR_W-1:0] A_CYCLE   = ADDR_W'(16'h002);
  localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(16'h003);
  localparam logic [ADDR_W-1:0] A_ARG0    = ADDR_W'(16'h010);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_done;
  logic              r_start_err;
  logic [DATA_W-1:0] r_cycle_cnt;
  logic [DATA_W-1:0] r_scratch;
  logic [DATA_W-1:0] r_args [NUM_ARGS];
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] w_rdata;
  logic              w_done_out;

  // Access decode
  logic w_wr, w_rd;
  logic w_start_req, w_soft_clr, w_done_clr, w_err_clr;
  logic w_finish;
  logic w_tmo_hit;
  logic w_tmo_flag;

  assign w_wr = ctrl.cl_ctrl_ce_ff & ctrl.cl_ctrl_we_ff;
  assign w_rd = ctrl.cl_ctrl_ce_ff & ~ctrl.cl_ctrl_we_ff;

  assign w_start_req = w_wr && (ctrl.cl_ctrl_addr_ff == A_CTRL)   && ctrl.cl_ctrl_d_ff[0];
  assign w_soft_clr  = w_wr && (ctrl.cl_ctrl_addr_ff == A_CTRL)   && ctrl.cl_ctrl_d_ff[1];
  assign w_done_clr  = w_wr && (ctrl.cl_ctrl_addr_ff == A_STATUS) && ctrl.cl_ctrl_d_ff[1];
  assign w_err_clr   = w_wr && (ctrl.cl_ctrl_addr_ff == A_STATUS) && ctrl.cl_ctrl_d_ff[2];

  // A run ends on the kernel's completion pulse, or on the timeout limit.
  // kernel_done outside BUSY is dropped here.
  assign w_finish = (r_state == S_BUSY) && (kernel_done || w_tmo_hit);

`ifdef SOCKET_CTRL_TIMEOUT_EN
  localparam logic [ADDR_W-1:0] A_TIMEOUT = ADDR_W'(16'h004);

  logic [DATA_W-1:0] r_tmo_lim;
  logic              r_tmo;
  logic [DATA_W:0]   w_cnt_inc;
  logic              w_tmo_clr;

  // Extra bit keeps the saturated counter from wrapping into a false match.
  assign w_cnt_inc  = {1'b0, r_cycle_cnt} + (DATA_W+1)'(1);
  assign w_tmo_hit  = (r_state == S_BUSY) && (r_tmo_lim != '0) &&
                      (w_cnt_inc == {1'b0, r_tmo_lim});
  assign w_tmo_clr  = w_wr && (ctrl.cl_ctrl_addr_ff == A_STATUS) && ctrl.cl_ctrl_d_ff[3];
  assign w_tmo_flag = r_tmo;

  // Timeout limit register
  always_ff @(posedge clk or posedge socket_reset) begin
    if (socket_reset)
      r_tmo_lim <= '0;
    else if (w_wr && (ctrl.cl_ctrl_addr_ff == A_TIMEOUT))
      r_tmo_lim <= ctrl.cl_ctrl_d_ff;
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear
  always_ff @(posedge clk or posedge socket_reset) begin
    if (socket_reset)
      r_tmo <= 1'b0;
    else if (w_soft_clr)
      r_tmo <= 1'b0;
    else if (w_tmo_hit)
      r_tmo <= 1'b1;
    else if (w_tmo_clr)
      r_tmo <= 1'b0;
  end
`else
  assign w_tmo_hit  = 1'b0;
  assign w_tmo_flag = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge socket_reset) begin
    if (socket_reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // FSM next state; soft_clear overrides every other event
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_req) w_state_nxt = S_START;
      S_START: w_state_nxt = S_BUSY;
      S_BUSY:  if (w_finish) w_state_nxt = S_DONE;
      S_DONE: begin
        if (w_start_req)     w_state_nxt = S_START;
        else if (w_done_clr) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_soft_clr)
      w_state_nxt = S_IDLE;
  end

  // FSM outputs decoded from the current state
  always_comb begin
    kernel_start = (r_state == S_START);
    kernel_busy  = (r_state == S_BUSY);
    w_done_out   = (r_state == S_DONE);
  end

  assign ctrl.cl_done_ff = w_done_out;

  // Sticky done flag; completion beats a simultaneous write-1-to-clear
  always_ff @(posedge clk or posedge socket_reset) begin
    if (socket_reset)
      r_done <= 1'b0;
    else if (w_soft_clr)
      r_done <= 1'b0;
    else if (w_finish)
      r_done <= 1'b1;
    else if ((r_state == S_DONE) && w_start_req)
      r_done <= 1'b0;
    else if (w_done_clr)
      r_done <= 1'b0;
  end

  // Sticky start error: a start request while a launch is in flight
  always_ff @(posedge clk or posedge socket_reset) begin
    if (socket_reset)
      r_start_err <= 1'b0;
    else if (w_soft_clr)
      r_start_err <= 1'b0;
    else if (w_start_req && ((r_state == S_START) || (r_state == S_BUSY)))
      r_start_err <= 1'b1;
    else if (w_err_clr)
      r_start_err <= 1'b0;
  end

  // Busy-cycle counter: cleared at launch, saturating count while busy
  always_ff @(posedge clk or posedge socket_reset) begin
    if (socket_reset)
      r_cycle_cnt <= '0;
    else if (w_soft_clr || (r_state == S_START))
      r_cycle_cnt <= '0;
    else if ((r_state == S_BUSY) && (r_cycle_cnt != '1))
      r_cycle_cnt <= r_cycle_cnt + DATA_W'(1);
  end

  // Scratch and argument registers; writes accepted in any state
  always_ff @(posedge clk or posedge socket_reset) begin
    if (socket_reset) begin
      r_scratch <= '0;
      for (int i = 0; i < NUM_ARGS; i++)
        r_args[i] <= '0;
    end else if (w_wr) begin
      if (ctrl.cl_ctrl_addr_ff == A_SCRATCH)
        r_scratch <= ctrl.cl_ctrl_d_ff;
      for (int i = 0; i < NUM_ARGS; i++)
        if (ctrl.cl_ctrl_addr_ff == A_ARG0 + ADDR_W'(i))
          r_args[i] <= ctrl.cl_ctrl_d_ff;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ARGS; gi++) begin : g_args_out
      assign kernel_args[gi*DATA_W +: DATA_W] = r_args[gi];
    end
  endgenerate

  // Read mux; CTRL and unmapped addresses return zero
  always_comb begin
    w_rdata = '0;
    case (ctrl.cl_ctrl_addr_ff)
      A_STATUS: begin
        w_rdata[0] = (r_state == S_BUSY);
        w_rdata[1] = r_done;
        w_rdata[2] = r_start_err;
        w_rdata[3] = w_tmo_flag;
      end
      A_CYCLE:   w_rdata = r_cycle_cnt;
      A_SCRATCH: w_rdata = r_scratch;
`ifdef SOCKET_CTRL_TIMEOUT_EN
      A_TIMEOUT: w_rdata = r_tmo_lim;
`endif
      default: begin
        for (int i = 0; i < NUM_ARGS; i++)
          if (ctrl.cl_ctrl_addr_ff == A_ARG0 + ADDR_W'(i))
            w_rdata = r_args[i];
      end
    endcase
  end

  // Read data pipeline; q only changes when a read result arrives
  generate
    if (Q_LAT == 2) begin : g_q_lat2
      logic              r_rd_v;
      logic [DATA_W-1:0] r_rd_d;
      always_ff @(posedge clk or posedge socket_reset) begin
        if (socket_reset) begin
          r_rd_v <= 1'b0;
          r_rd_d <= '0;
          r_q    <= '0;
        end else begin
          r_rd_v <= w_rd;
          if (w_rd)
            r_rd_d <= w_rdata;
          if (r_rd_v)
            r_q <= r_rd_d;
        end
      end
    end else begin : g_q_lat1
      always_ff @(posedge clk or posedge socket_reset) begin
        if (socket_reset)
          r_q <= '0;
        else if (w_rd)
          r_q <= w_rdata;
      end
    end
  endgenerate

  assign ctrl.cl_ctrl_q_ff = r_q;

endmodule
`default_nettype wire
